// File: rtl/svm_mac_array.sv
// Linear-kernel SVM scoring datapath: a skewed chain of MAC stages computes
// dot(sv, x) for each beat. A tracker sums the dot products of one instance
// and stores the score in a small results table.
module svm_mac_array #(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned ACCUM_SIZE = 64,
  parameter int unsigned NUM_FEAT   = 2,
  parameter int unsigned NUM_SV     = 3,
  parameter int unsigned NUM_INST   = 2,
  localparam int unsigned VEC_W  = NUM_FEAT * DATA_SIZE,
  localparam int unsigned IDX_W  = (NUM_INST > 1) ? $clog2(NUM_INST) : 1,
  localparam int unsigned PROD_W = (2 * DATA_SIZE > ACCUM_SIZE) ? 2 * DATA_SIZE : ACCUM_SIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic [VEC_W-1:0]               sv,
  input  logic [VEC_W-1:0]               x,
  output logic                           res_valid,
  output logic [ACCUM_SIZE-1:0]          res_data,
  output logic [IDX_W-1:0]               res_index,
  output logic                           done,
  output logic [NUM_INST*ACCUM_SIZE-1:0] results
);

  if (NUM_FEAT < 1 || NUM_SV < 1 || NUM_INST < 1) begin : g_param_check
    $error("svm_mac_array: NUM_FEAT, NUM_SV and NUM_INST must all be >= 1");
  end

  // Input register; in_x_q doubles as the held instance vector.
  logic             in_v_q, in_f_q, in_l_q;
  logic [VEC_W-1:0] in_sv_q, in_x_q;

  // Per-stage pipeline state. Each beat carries its own copy of x so a new
  // first beat never disturbs beats of the previous instance still in flight.
  logic                  st_v_q  [NUM_FEAT];
  logic                  st_f_q  [NUM_FEAT];
  logic                  st_l_q  [NUM_FEAT];
  logic [VEC_W-1:0]      st_sv_q [NUM_FEAT];
  logic [VEC_W-1:0]      st_x_q  [NUM_FEAT];
  logic [ACCUM_SIZE-1:0] st_ps_q [NUM_FEAT];

  // Capture the accepted beat; latch x only on first beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_v_q  <= 1'b0;
      in_f_q  <= 1'b0;
      in_l_q  <= 1'b0;
      in_sv_q <= '0;
      in_x_q  <= '0;
    end else begin
      in_v_q <= in_valid;
      in_f_q <= in_valid & in_first;
      in_l_q <= in_valid & in_last;
      if (in_valid) in_sv_q <= sv;
      if (in_valid && in_first) in_x_q <= x;
    end
  end

  for (genvar f = 0; f < NUM_FEAT; f++) begin : g_stage
    logic                  v_in, f_in, l_in;
    logic [VEC_W-1:0]      sv_in, x_in;
    logic [ACCUM_SIZE-1:0] ps_in;
    logic [PROD_W-1:0]     prod;

    if (f == 0) begin : g_head
      assign v_in  = in_v_q;
      assign f_in  = in_f_q;
      assign l_in  = in_l_q;
      assign sv_in = in_sv_q;
      assign x_in  = in_x_q;
      assign ps_in = '0;
    end else begin : g_body
      assign v_in  = st_v_q[f-1];
      assign f_in  = st_f_q[f-1];
      assign l_in  = st_l_q[f-1];
      assign sv_in = st_sv_q[f-1];
      assign x_in  = st_x_q[f-1];
      assign ps_in = st_ps_q[f-1];
    end

    // Operands widened first so the product is exact before truncation.
    assign prod = PROD_W'(sv_in[f*DATA_SIZE +: DATA_SIZE]) *
                  PROD_W'(x_in[f*DATA_SIZE +: DATA_SIZE]);

    // MAC stage f: add this feature's product to the incoming partial sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_v_q[f]  <= 1'b0;
        st_f_q[f]  <= 1'b0;
        st_l_q[f]  <= 1'b0;
        st_sv_q[f] <= '0;
        st_x_q[f]  <= '0;
        st_ps_q[f] <= '0;
      end else begin
        st_v_q[f]  <= v_in;
        st_f_q[f]  <= f_in;
        st_l_q[f]  <= l_in;
        st_sv_q[f] <= sv_in;
        st_x_q[f]  <= x_in;
        st_ps_q[f] <= ps_in + prod[ACCUM_SIZE-1:0];
      end
    end
  end

  logic                  dot_v, dot_f, dot_l;
  logic [ACCUM_SIZE-1:0] dot;
  logic [ACCUM_SIZE-1:0] acc_q, sum;
  logic [IDX_W-1:0]      cnt_q;
  logic                  cnt_wrap;
  logic [ACCUM_SIZE-1:0] tbl_q [NUM_INST];

  assign dot_v    = st_v_q[NUM_FEAT-1];
  assign dot_f    = st_f_q[NUM_FEAT-1];
  assign dot_l    = st_l_q[NUM_FEAT-1];
  assign dot      = st_ps_q[NUM_FEAT-1];
  assign cnt_wrap = (cnt_q == IDX_W'(NUM_INST - 1));

  // Running instance sum; a first beat restarts from zero.
  always_comb begin
    sum = (dot_f ? '0 : acc_q) + dot;
  end

  // Result tracker: accumulate, publish on last beat, fill table slots in turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
      done      <= 1'b0;
      for (int n = 0; n < NUM_INST; n++) tbl_q[n] <= '0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      if (dot_v) begin
        acc_q <= sum;
        if (dot_l) begin
          res_valid    <= 1'b1;
          res_data     <= sum;
          res_index    <= cnt_q;
          tbl_q[cnt_q] <= sum;
          done         <= cnt_wrap;
          cnt_q        <= cnt_wrap ? '0 : cnt_q + 1'b1;
        end
      end
    end
  end

  // Flatten the results table onto the output bus.
  always_comb begin
    results = '0;
    for (int n = 0; n < NUM_INST; n++) results[n*ACCUM_SIZE +: ACCUM_SIZE] = tbl_q[n];
  end

endmodule

// File: tb/tb_svm_mac_array.sv
module tb_svm_mac_array;
  localparam int unsigned DS = 32;
  localparam int unsigned AS = 64;
  localparam int unsigned NF = 2;
  localparam int unsigned NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [NF*DS-1:0] sv = '0, x = '0;
  logic             res_valid;
  logic [AS-1:0]    res_data;
  logic             res_index;
  logic             done;
  logic [NI*AS-1:0] results;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  int          q_edge[$];
  logic [63:0] q_data[$];
  logic        q_idx[$];
  logic        q_done[$];

  svm_mac_array #(
    .DATA_SIZE(DS), .ACCUM_SIZE(AS), .NUM_FEAT(NF), .NUM_SV(3), .NUM_INST(NI)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .sv(sv), .x(x), .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .done(done), .results(results)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse with the edge number it appeared after.
  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
    if (res_valid) begin
      q_edge.push_back(cyc);
      q_data.push_back(res_data);
      q_idx.push_back(res_index);
      q_done.push_back(done);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic f, input logic l, input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] x0, input logic [31:0] x1, output int edge_n);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    sv = {s1, s0};
    x  = {x1, x0};
    @(posedge clk);
    #1;
    edge_n   = cyc;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Three back-to-back SVs (1,2),(3,4),(5,6); x garbage on non-first beats.
  task automatic inst(input logic [31:0] x0, input logic [31:0] x1, output int e_first,
                      output int e_last);
    int e;
    beat(1'b1, 1'b0, 1, 2, x0, x1, e_first);
    beat(1'b0, 1'b0, 3, 4, 32'hDEAD, 32'hBEEF, e);
    beat(1'b0, 1'b1, 5, 6, 32'h1234, 32'h5678, e_last);
  endtask

  task automatic check_res(input string tag, input int exp_edge, input logic [63:0] d,
                           input logic idx, input logic dn);
    checks++;
    assert (q_edge.size() > 0) else begin
      failures++;
      $error("FAIL %s_present: got 0 results expected 1", tag);
    end
    if (q_edge.size() > 0) begin
      chk({tag, "_edge"}, 64'(q_edge.pop_front()), 64'(exp_edge));
      chk({tag, "_data"}, q_data.pop_front(), d);
      chk({tag, "_index"}, 64'(q_idx.pop_front()), 64'(idx));
      chk({tag, "_done"}, 64'(q_done.pop_front()), 64'(dn));
    end
  endtask

  initial begin
    int ea, eb, ec, ed, ee, ef;

    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_index", 64'(res_index), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_slot0", results[63:0], 64'd0);
    chk("rst_slot1", results[127:64], 64'd0);

    // Tests 1 and 2: two instances streamed back to back.
    inst(1, 1, ea, eb);
    inst(2, 0, ec, ed);
    idle(6);
    check_res("t1", eb + 3, 64'h15, 1'b0, 1'b0);
    check_res("t2", ed + 3, 64'h12, 1'b1, 1'b1);
    chk("t2_slot0", results[63:0], 64'h15);
    chk("t2_slot1", results[127:64], 64'h12);

    // Test 3: two-cycle bubble after the first beat.
    beat(1'b1, 1'b0, 1, 2, 1, 1, ea);
    idle(2);
    beat(1'b0, 1'b0, 3, 4, 32'h77, 32'h99, eb);
    beat(1'b0, 1'b1, 5, 6, 32'hFFFF, 32'h3, ec);
    idle(5);
    check_res("t3", ea + 7, 64'h15, 1'b0, 1'b0);
    chk("t3_pulse_ended", 64'(res_valid), 64'd0);
    chk("t3_data_held", res_data, 64'h15);

    // Test 4: full-scale operands, single-SV instance, wrapping sum.
    beat(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ea);
    idle(5);
    check_res("t4", ea + 3, 64'hFFFFFFFC00000002, 1'b1, 1'b1);
    chk("t4_slot1", results[127:64], 64'hFFFFFFFC00000002);

    // Test 5: reset while a complete instance is still in the pipe.
    beat(1'b1, 1'b0, 1, 2, 1, 1, ea);
    beat(1'b0, 1'b1, 3, 4, 1, 1, eb);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);
    chk("t5_no_result", 64'(q_edge.size()), 64'd0);
    q_edge.delete(); q_data.delete(); q_idx.delete(); q_done.delete();
    chk("t5_slot0_clr", results[63:0], 64'd0);
    chk("t5_slot1_clr", results[127:64], 64'd0);
    chk("t5_data_clr", res_data, 64'd0);
    inst(1, 1, ea, eb);
    idle(6);
    check_res("t5", eb + 3, 64'h15, 1'b0, 1'b0);
    chk("t5_slot0", results[63:0], 64'h15);
    chk("t5_slot1", results[127:64], 64'd0);

    // Test 6: three instances from a fresh reset; third wraps to slot 0.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    done_cnt = 0;
    inst(1, 1, ea, eb);
    inst(2, 0, ec, ed);
    inst(1, 1, ee, ef);
    idle(6);
    check_res("t6a", eb + 3, 64'h15, 1'b0, 1'b0);
    check_res("t6b", ed + 3, 64'h12, 1'b1, 1'b1);
    check_res("t6c", ef + 3, 64'h15, 1'b0, 1'b0);
    chk("t6_slot0", results[63:0], 64'h15);
    chk("t6_slot1", results[127:64], 64'h12);
    chk("t6_done_count", 64'(done_cnt), 64'd1);
    chk("t6_no_extra", 64'(q_edge.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
